// File: rtl/pin_demerge_rx_if.sv
// Merged-pin receive bundle: serial pin in, recovered bus and status out.
// The transmitter side (or bench) uses master, the receiver uses slave.
interface pin_demerge_rx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             sdin;
  logic             en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             par_err;
  logic             frm_err;
  logic [CNT_W-1:0] good_cnt;
  logic             busy;

  modport master (
    output sdin,
    output en,
    input  dout,
    input  dout_valid,
    input  par_err,
    input  frm_err,
    input  good_cnt,
    input  busy
  );

  modport slave (
    input  sdin,
    input  en,
    output dout,
    output dout_valid,
    output par_err,
    output frm_err,
    output good_cnt,
    output busy
  );
endinterface

// File: rtl/pin_demerge_rx.sv
// Deserializes start/data/even-parity/stop frames from one merged pin
// and publishes the recovered bus with registered strobes and a counter.
module pin_demerge_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pin_demerge_rx_if.slave     bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_RESYNC = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             par_q, par_d;
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             pe_q, pe_d;
  logic             fe_q, fe_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;

  logic sdin;
  logic en;

  assign sdin = bus.sdin;
  assign en   = bus.en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    perr_d  = perr_q;
    dout_d  = dout_q;
    gcnt_d  = gcnt_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    // Disable aborts silently from any active state.
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sdin) begin
            state_d = S_DATA;
            cnt_d   = '0;
            sh_d    = '0;
            par_d   = 1'b0;
          end
        end

        S_DATA: begin
          sh_d[cnt_q] = sdin;
          par_d       = par_q ^ sdin;
          if (cnt_q == LAST) begin
            state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_PARITY: begin
          perr_d  = sdin ^ par_q;
          state_d = S_STOP;
        end

        S_STOP: begin
          if (sdin) begin
            // Bad stop bit outranks a parity mismatch.
            fe_d    = 1'b1;
            state_d = S_RESYNC;
          end else begin
            state_d = S_IDLE;
            if (perr_q) begin
              pe_d = 1'b1;
            end else begin
              dout_d = sh_q;
              dv_d   = 1'b1;
              gcnt_d = gcnt_q + 1'b1;
            end
          end
        end

        S_RESYNC: begin
          if (!sdin) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.frm_err    = fe_q;
  assign bus.good_cnt   = gcnt_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pin_demerge_rx.sv
// Directed bench for pin_demerge_rx: frames are driven serially and the
// expected strobe of each frame is queued and matched when it appears.
module tb_pin_demerge_rx;

  logic clk;
  logic rst_n;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    int         kind;
    logic [3:0] data;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] m_dout;
  logic [7:0] m_cnt;
  logic [7:0] cnt_before;

  pin_demerge_rx_if #(.WIDTH(4), .CNT_W(8)) bus ();

  pin_demerge_rx #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.sdin = b;
  endtask

  task automatic send_frame(input logic [3:0] d, input bit bad_par,
                            input bit bad_stop);
    exp_t e;
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    @(negedge clk);
    bus.sdin = bad_stop;
    e.due = cyc + 1;
    if (bad_stop) begin
      e.kind = 2;
    end else if (bad_par) begin
      e.kind = 1;
    end else begin
      m_dout = d;
      m_cnt  = m_cnt + 8'd1;
      e.kind = 0;
    end
    e.data = m_dout;
    e.cnt  = m_cnt;
    sbq.push_back(e);
  endtask

  int   n_str;
  int   got_kind;
  exp_t got;

  always @(negedge clk) begin
    if (rst_n) begin
      n_str = int'(bus.dout_valid) + int'(bus.par_err) + int'(bus.frm_err);
      if (n_str > 0) begin
        chk("strobe_exclusive", 32'(n_str), 32'd1);
        got_kind = bus.dout_valid ? 0 : (bus.par_err ? 1 : 2);
        if (sbq.size() == 0) begin
          chk("unexpected_strobe",
              {29'd0, bus.dout_valid, bus.par_err, bus.frm_err}, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk("strobe_kind", 32'(got_kind), 32'(got.kind));
          chk("strobe_cycle", 32'(cyc), 32'(got.due));
          chk("dout", {28'd0, bus.dout}, {28'd0, got.data});
          chk("good_cnt", {24'd0, bus.good_cnt}, {24'd0, got.cnt});
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        got = sbq.pop_front();
        chk("strobe_missing", 32'd0, 32'(got.kind) + 32'd1);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_dout   = '0;
    m_cnt    = '0;
    rst_n    = 1'b0;
    bus.sdin = 1'b0;
    bus.en   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_dout", {28'd0, bus.dout}, 32'd0);
    chk("rst_strobes",
        {29'd0, bus.dout_valid, bus.par_err, bus.frm_err}, 32'd0);
    chk("rst_cnt", {24'd0, bus.good_cnt}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n  = 1'b1;
    bus.en = 1'b1;
    repeat (2) @(negedge clk);

    // good frame A
    send_frame(4'hA, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("good_A_dout", {28'd0, bus.dout}, 32'hA);
    chk("good_A_cnt", {24'd0, bus.good_cnt}, 32'd1);

    // parity error: data 1 with parity 0
    send_frame(4'h1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("perr_dout", {28'd0, bus.dout}, 32'hA);
    chk("perr_cnt", {24'd0, bus.good_cnt}, 32'd1);

    // framing error, trailing ones, then recovery
    send_frame(4'h3, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    chk("resync_busy", {31'd0, bus.busy}, 32'd1);
    bus.sdin = 1'b0;
    @(negedge clk);
    chk("resync_idle", {31'd0, bus.busy}, 32'd0);
    send_frame(4'h3, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("recover_dout", {28'd0, bus.dout}, 32'h3);

    // abort after second data bit
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.en   = 1'b0;
    bus.sdin = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_dout", {28'd0, bus.dout}, {28'd0, m_dout});
    chk("abort_cnt", {24'd0, bus.good_cnt}, {24'd0, m_cnt});
    @(negedge clk);
    chk("disabled_idle", {31'd0, bus.busy}, 32'd0);
    bus.sdin = 1'b0;
    bus.en   = 1'b1;
    send_frame(4'h5, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("after_abort_dout", {28'd0, bus.dout}, 32'h5);

    // 256 back-to-back frames wrap the counter to its start value
    cnt_before = m_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(4'(i * 7 + 3), 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.sdin = 1'b0;
    @(negedge clk);
    chk("wrap_cnt", {24'd0, bus.good_cnt}, {24'd0, cnt_before});
    chk("wrap_dout", {28'd0, bus.dout}, {28'd0, 4'(255 * 7 + 3)});

    // reset during the parity bit
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    bus.sdin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", {28'd0, bus.dout}, 32'd0);
    chk("midrst_cnt", {24'd0, bus.good_cnt}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_strobes",
        {29'd0, bus.dout_valid, bus.par_err, bus.frm_err}, 32'd0);
    m_dout = '0;
    m_cnt  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'hF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_rst_dout", {28'd0, bus.dout}, 32'hF);
    chk("post_rst_cnt", {24'd0, bus.good_cnt}, 32'd1);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
